i2c_sensor_slave_emu: RTL and testbench

Synthesizable, parametrised I2C slave that emulates a multi-register sensor on the integration bus. It supports register-pointer writes, burst writes with auto-increment, and burst reads with repeated START. The host side preloads sensor values, such as temperature, humidity and motion counts, through a register-load port. It replaces fixed single-byte responders so that controller read sequences can be exercised against realistic register maps.

---
 rtl/i2c_sensor_slave_emu.sv | 247 ++++++++++++++++++++++++
 tb/tb_i2c_sensor_slave_emu.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_sensor_slave_emu.sv
// I2C slave emulating a multi-register sensor: pointer writes, auto-increment burst writes/reads.
// Optional SCL stretching after a read-address ACK is built when I2C_STRETCH_EN is defined.
module i2c_sensor_slave_emu #(
  parameter logic [6:0] SLAVE_ADDR     = 7'h48,
  parameter int         NUM_REGS       = 4,
  parameter int         STRETCH_CYCLES = 64,
  localparam int        PTR_W          = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             scl_oe,
  input  logic             reg_ld_en,
  input  logic [PTR_W-1:0] reg_ld_addr,
  input  logic [7:0]       reg_ld_data,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  if (NUM_REGS < 2 || NUM_REGS > 256 || STRETCH_CYCLES < 1) begin : g_param_check
    $error("i2c_sensor_slave_emu: NUM_REGS must be 2..256 and STRETCH_CYCLES >= 1");
  end

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
  } state_t;

  // Bus idles high, so the synchronisers reset to 1 to avoid a phantom edge.
  logic scl_meta, scl_sync, scl_prev;
  logic sda_meta, sda_sync, sda_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {scl_meta, scl_sync, scl_prev} <= 3'b111;
      {sda_meta, sda_sync, sda_prev} <= 3'b111;
    end else begin
      {scl_meta, scl_sync, scl_prev} <= {scl_i, scl_meta, scl_sync};
      {sda_meta, sda_sync, sda_prev} <= {sda_i, sda_meta, sda_sync};
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_sync & ~scl_prev;
  assign scl_fall  = ~scl_sync & scl_prev;
  assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
  assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;

  state_t           state_reg, state_next;
  logic [3:0]       bit_cnt_reg, bit_cnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic             rw_reg, rw_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic             sda_oe_reg, sda_oe_next;
  logic             busy_reg, busy_next;
  logic             wr_strobe_reg, wr_strobe_next;
  logic [PTR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [7:0]       wr_data_reg, wr_data_next;
  logic             i2c_we;
  logic [7:0]       regs [NUM_REGS];

  logic [7:0]       byte_in;
  logic [PTR_W-1:0] ptr_inc;
  assign byte_in = {shift_reg[6:0], sda_sync};
  assign ptr_inc = (ptr_reg == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_reg + 1'b1;

`ifdef I2C_STRETCH_EN
  localparam int SC_W = $clog2(STRETCH_CYCLES + 1);
  logic            scl_oe_reg, scl_oe_next;
  logic [SC_W-1:0] stretch_cnt_reg, stretch_cnt_next;
  assign scl_oe = scl_oe_reg;
`else
  assign scl_oe = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    rw_next        = rw_reg;
    ptr_next       = ptr_reg;
    sda_oe_next    = sda_oe_reg;
    busy_next      = busy_reg;
    wr_strobe_next = 1'b0;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    i2c_we         = 1'b0;
`ifdef I2C_STRETCH_EN
    scl_oe_next      = scl_oe_reg;
    stretch_cnt_next = stretch_cnt_reg;
    if (scl_oe_reg) begin
      if (stretch_cnt_reg == SC_W'(1)) scl_oe_next = 1'b0;
      else stretch_cnt_next = stretch_cnt_reg - 1'b1;
    end
`endif

    if (stop_det) begin
      state_next   = IDLE;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
`ifdef I2C_STRETCH_EN
      scl_oe_next  = 1'b0;
`endif
    end else if (start_det) begin
      state_next   = ADDR;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
    end else begin
      unique case (state_reg)
        ADDR, PTR, WDATA: if (scl_rise) begin
          shift_next = byte_in;
          if (bit_cnt_reg == 4'd7) begin
            bit_cnt_next = '0;
            if (state_reg == ADDR) begin
              rw_next = sda_sync;
              if (byte_in[7:1] == SLAVE_ADDR) begin
                state_next = ADDR_ACK;
                busy_next  = 1'b1;
              end else begin
                state_next = IGNORE;
              end
            end else if (state_reg == PTR) begin
              if ({1'b0, byte_in} < 9'(NUM_REGS)) begin
                ptr_next   = byte_in[PTR_W-1:0];
                state_next = PTR_ACK;
              end else begin
                state_next = IGNORE;
              end
            end else begin
              i2c_we         = 1'b1;
              wr_strobe_next = 1'b1;
              wr_addr_next   = ptr_reg;
              wr_data_next   = byte_in;
              ptr_next       = ptr_inc;
              state_next     = WDATA_ACK;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
        // bit_cnt 0: ACK slot not yet started; 1: ACK being driven.
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
          if (bit_cnt_reg == 4'd0) begin
            sda_oe_next  = 1'b1;
            bit_cnt_next = 4'd1;
          end else begin
            bit_cnt_next = '0;
            if (state_reg == ADDR_ACK && rw_reg) begin
              shift_next  = regs[ptr_reg];
              sda_oe_next = ~regs[ptr_reg][7];
              state_next  = RDATA;
`ifdef I2C_STRETCH_EN
              scl_oe_next      = 1'b1;
              stretch_cnt_next = SC_W'(STRETCH_CYCLES);
`endif
            end else begin
              sda_oe_next = 1'b0;
              state_next  = (state_reg == ADDR_ACK) ? PTR : WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_rise) bit_cnt_next = bit_cnt_reg + 1'b1;
          else if (scl_fall) begin
            if (bit_cnt_reg == 4'd8) begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = '0;
              state_next   = RACK;
            end else begin
              shift_next  = {shift_reg[6:0], 1'b0};
              sda_oe_next = ~shift_reg[6];
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            if (sda_sync) state_next = IGNORE;
            else begin
              ptr_next     = ptr_inc;
              bit_cnt_next = 4'd1;
            end
          end else if (scl_fall && bit_cnt_reg == 4'd1) begin
            bit_cnt_next = '0;
            shift_next   = regs[ptr_reg];
            sda_oe_next  = ~regs[ptr_reg][7];
            state_next   = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      rw_reg        <= 1'b0;
      ptr_reg       <= '0;
      sda_oe_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      wr_strobe_reg <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
`ifdef I2C_STRETCH_EN
      scl_oe_reg      <= 1'b0;
      stretch_cnt_reg <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      rw_reg        <= rw_next;
      ptr_reg       <= ptr_next;
      sda_oe_reg    <= sda_oe_next;
      busy_reg      <= busy_next;
      wr_strobe_reg <= wr_strobe_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
`ifdef I2C_STRETCH_EN
      scl_oe_reg      <= scl_oe_next;
      stretch_cnt_reg <= stretch_cnt_next;
`endif
    end
  end

  // A bus write to the same register as a host load takes priority.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
    always_ff @(posedge clk or posedge rst) begin
      if (rst) regs[gi] <= '0;
      else if (i2c_we && ptr_reg == PTR_W'(gi)) regs[gi] <= byte_in;
      else if (reg_ld_en && reg_ld_addr == PTR_W'(gi)) regs[gi] <= reg_ld_data;
    end
  end

  assign sda_oe    = sda_oe_reg;
  assign busy      = busy_reg;
  assign wr_strobe = wr_strobe_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;

endmodule

// File: tb/tb_i2c_sensor_slave_emu.sv
// Directed bench: a bit-banged I2C master on a wired-AND bus drives the sensor emulator.
module tb_i2c_sensor_slave_emu;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_line, sda_line;
  logic       sda_oe, scl_oe, reg_ld_en, wr_strobe, busy;
  logic [1:0] reg_ld_addr, wr_addr;
  logic [7:0] reg_ld_data, wr_data;

  int check_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  assign scl_line = scl_m & ~scl_oe;
  assign sda_line = sda_m & ~sda_oe;

  i2c_sensor_slave_emu dut (
    .clk(clk), .rst(rst), .scl_i(scl_line), .sda_i(sda_line),
    .sda_oe(sda_oe), .scl_oe(scl_oe),
    .reg_ld_en(reg_ld_en), .reg_ld_addr(reg_ld_addr), .reg_ld_data(reg_ld_data),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  // Bus monitor, sampled mid-cycle.
  logic [15:0] wr_log [64];
  int wr_cnt = 0, sda_oe_cycles = 0, busy_cycles = 0, scl_oe_cycles = 0;
  logic sda_at_release = 1'b0;
  always @(negedge clk) begin
    if (wr_strobe && wr_cnt < 64) begin
      wr_log[wr_cnt] <= {6'd0, wr_addr, wr_data};
      wr_cnt <= wr_cnt + 1;
    end
    if (sda_oe) sda_oe_cycles <= sda_oe_cycles + 1;
    if (busy) busy_cycles <= busy_cycles + 1;
    if (scl_oe) begin
      scl_oe_cycles  <= scl_oe_cycles + 1;
      sda_at_release <= sda_oe;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    $display("check %-14s got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_high();
    int n = 0;
    scl_m = 1'b1;
    @(negedge clk);
    while (scl_line !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("scl_timeout", 32'(n), 0);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(H);
    scl_high();   tick(H);
    sda_m = 1'b0; tick(H);
    scl_m = 1'b0; tick(2);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(H);
    scl_high();   tick(H);
    sda_m = 1'b1; tick(H);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; tick(H);
    scl_high(); tick(H);
    scl_m = 1'b0; tick(2);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic nack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; tick(H);
    scl_high(); tick(H / 2);
    nack = sda_line;
    tick(H / 2);
    scl_m = 1'b0; tick(2);
  endtask

  task automatic read_byte(input logic nack_bit, output logic [7:0] d);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(H);
      scl_high(); tick(H / 2);
      d[i] = sda_line;
      tick(H / 2);
      scl_m = 1'b0; tick(2);
    end
    sda_m = nack_bit; tick(H);
    scl_high(); tick(H);
    scl_m = 1'b0; tick(2);
    sda_m = 1'b1;
  endtask

  task automatic host_load(input logic [1:0] a, input logic [7:0] d);
    reg_ld_en = 1'b1; reg_ld_addr = a; reg_ld_data = d;
    tick(1);
    reg_ld_en = 1'b0;
  endtask

  // Set pointer, repeated START, read n bytes (ACK all but the last), STOP.
  task automatic read_txn(input string tag, input logic [7:0] ptr, input int n,
                          input logic [7:0] exp [4]);
    logic nack;
    logic [7:0] d;
    i2c_start();
    write_byte(8'h90, nack); check({tag, "_ackA"}, nack, 0);
    write_byte(ptr, nack);   check({tag, "_ackP"}, nack, 0);
    i2c_start();
    write_byte(8'h91, nack); check({tag, "_ackR"}, nack, 0);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      check($sformatf("%s_rd%0d", tag, i), d, exp[i]);
    end
    i2c_stop();
  endtask

  initial begin
    logic nack;
    logic [7:0] exp [4];
    int base_wr, base_sda, base_busy;
    reg_ld_en = 1'b0; reg_ld_addr = '0; reg_ld_data = '0;

    tick(4);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_data", wr_data, 0);
    rst = 1'b0;
    tick(4);

    // 1: host preload, pointer write, repeated-START burst read
    host_load(2'd0, 8'h19);
    host_load(2'd1, 8'h32);
    base_wr = wr_cnt;
    i2c_start();
    write_byte(8'h90, nack); check("t1_ackA", nack, 0);
    check("t1_busy", busy, 1);
    write_byte(8'h00, nack); check("t1_ackP", nack, 0);
    i2c_start();
    write_byte(8'h91, nack); check("t1_ackR", nack, 0);
    read_byte(1'b0, exp[0]); check("t1_rd0", exp[0], 8'h19);
    read_byte(1'b1, exp[1]); check("t1_rd1", exp[1], 8'h32);
    check("t1_busy_pre", busy, 1);
    i2c_stop();
    tick(4);
    check("t1_busy_stop", busy, 0);
    check("t1_no_wr", 32'(wr_cnt - base_wr), 0);

    // 2: burst write wrapping 3 -> 0, then read back
    base_wr = wr_cnt;
    i2c_start();
    write_byte(8'h90, nack); check("t2_ackA", nack, 0);
    write_byte(8'h03, nack); check("t2_ackP", nack, 0);
    write_byte(8'hA5, nack); check("t2_ackD0", nack, 0);
    write_byte(8'h5A, nack); check("t2_ackD1", nack, 0);
    i2c_stop();
    tick(2);
    check("t2_wr_cnt", 32'(wr_cnt - base_wr), 2);
    check("t2_wr0", wr_log[base_wr], 16'h03A5);
    check("t2_wr1", wr_log[base_wr + 1], 16'h005A);
    exp = '{8'hA5, 8'h5A, 8'h00, 8'h00};
    read_txn("t2", 8'h03, 2, exp);

    // 3: wrong address is ignored entirely
    base_wr = wr_cnt; base_sda = sda_oe_cycles; base_busy = busy_cycles;
    i2c_start();
    write_byte(8'h92, nack); check("t3_nackA", nack, 1);
    write_byte(8'h77, nack); check("t3_nackD", nack, 1);
    i2c_stop();
    tick(2);
    check("t3_sda_oe", 32'(sda_oe_cycles - base_sda), 0);
    check("t3_busy", 32'(busy_cycles - base_busy), 0);
    check("t3_no_wr", 32'(wr_cnt - base_wr), 0);

    // 4: pointer out of range NACKed, data ignored, registers intact
    base_wr = wr_cnt;
    i2c_start();
    write_byte(8'h90, nack); check("t4_ackA", nack, 0);
    write_byte(8'h04, nack); check("t4_nackP", nack, 1);
    write_byte(8'hEE, nack); check("t4_nackD", nack, 1);
    i2c_stop();
    check("t4_no_wr", 32'(wr_cnt - base_wr), 0);
    exp = '{8'h5A, 8'h32, 8'h00, 8'hA5};
    read_txn("t4", 8'h00, 4, exp);

    // 5: STOP mid-byte discards it; next write works
    base_wr = wr_cnt;
    i2c_start();
    write_byte(8'h90, nack); check("t5_ackA", nack, 0);
    write_byte(8'h01, nack); check("t5_ackP", nack, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    check("t5_partial", 32'(wr_cnt - base_wr), 0);
    i2c_start();
    write_byte(8'h90, nack); check("t5_ackA2", nack, 0);
    write_byte(8'h02, nack); check("t5_ackP2", nack, 0);
    write_byte(8'h3C, nack); check("t5_ackD2", nack, 0);
    i2c_stop();
    check("t5_wr", wr_log[base_wr], 16'h023C);
    exp = '{8'h32, 8'h3C, 8'h00, 8'h00};
    read_txn("t5", 8'h01, 2, exp);

    // 5b: reset in mid-read
    i2c_start();
    write_byte(8'h90, nack);
    write_byte(8'h00, nack);
    i2c_start();
    write_byte(8'h91, nack); check("t5r_ackR", nack, 0);
    tick(6);
    check("t5r_drive", sda_oe, 1);
    rst = 1'b1;
    #1;
    check("t5r_sda_oe", sda_oe, 0);
    check("t5r_busy", busy, 0);
    check("t5r_wr_addr", wr_addr, 0);
    scl_m = 1'b1; sda_m = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(4);
    exp = '{8'h00, 8'h00, 8'h00, 8'h00};
    read_txn("t5z", 8'h00, 4, exp);

`ifdef I2C_STRETCH_EN
    // 6: SCL stretch after read-address ACK, first bit already on SDA
    host_load(2'd0, 8'h3C);
    base_sda = scl_oe_cycles;
    exp = '{8'h3C, 8'h00, 8'h00, 8'h00};
    read_txn("t6", 8'h00, 1, exp);
    check("t6_stretch", 32'(scl_oe_cycles - base_sda), 64);
    check("t6_bit_ready", sda_at_release, 1);
`else
    check("no_stretch", 32'(scl_oe_cycles), 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
